// File: rtl/pie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pie_pkg
// Description : Shared types and constants for the PIE frame assembler:
//               FSM state encoding, error_code values and the default sync
//               word.
// Revision    : 1.0 - initial release
// ============================================================================
package pie_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/pie_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module      : pie_symbol_timer
// Description : Saturating inter-symbol cycle counter. The count restarts
//               from 0 on every clear and otherwise climbs to
//               TIMEOUT_CYCLES-1, where it sticks.
// Ports       : sclk_3mhz  - system clock
//               reset      - synchronous active-high reset
//               i_clear    - a symbol strobe was seen this cycle
//               o_expired  - this cycle's edge brings the count to
//                            TIMEOUT_CYCLES-1 (single-cycle per idle run)
// Revision    : 1.0 - initial release
// ============================================================================
module pie_symbol_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic sclk_3mhz,
    input  logic reset,
    input  logic i_clear,
    output logic o_expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LIMIT     = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PRE_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 2);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge sclk_3mhz) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (r_count != c_LIMIT) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Flagged one cycle early so the consumer's registered reaction lands on
    // the same edge at which the count actually reaches the limit. Once the
    // count has saturated this stays low, so each idle run fires only once.
    assign o_expired = !i_clear && (r_count == c_PRE_LIMIT);

endmodule
`default_nettype wire

// File: rtl/pie_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : pie_frame_assembler
// Description : Consumes decoded PIE symbol strobes, hunts for a sync word,
//               then packs PAYLOAD_BYTES bytes MSB first into a one-deep
//               valid/ready output register. Reports frame completion and
//               aborts on symbol conflict, output overflow or timeout.
// Ports       : sclk_3mhz    - system clock
//               reset        - synchronous active-high reset
//               zero_detect  - one-cycle strobe, decoded symbol 0
//               one_detect   - one-cycle strobe, decoded symbol 1
//               byte_data    - assembled payload byte
//               byte_valid   - byte_data valid, held until accepted
//               byte_ready   - consumer accepts on byte_valid && byte_ready
//               frame_active - high while receiving payload
//               frame_done   - pulse when the last payload byte is loaded
//               frame_error  - pulse on frame abort
//               error_code   - 0 none, 1 timeout, 2 overflow, 3 conflict
// Revision    : 1.0 - initial release
// ============================================================================
module pie_frame_assembler
    import pie_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
    parameter int         PAYLOAD_BYTES  = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       sclk_3mhz,
    input  logic       reset,
    input  logic       zero_detect,
    input  logic       one_detect,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_active,
    output logic       frame_done,
    output logic       frame_error,
    output logic [1:0] error_code
);

    localparam logic [3:0] c_LAST_BYTE = 4'(PAYLOAD_BYTES - 1);

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_sync_sr;
    logic [7:0] r_byte_sr;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_byte_cnt;
    logic [7:0] r_byte_data;
    logic       r_byte_valid;
    logic       r_frame_done;
    logic       r_frame_error;
    logic [1:0] r_error_code;

    logic       w_sym;
    logic       w_conflict;
    logic       w_strobe;
    logic       w_bit;
    logic       w_expired;
    logic [7:0] w_sync_shift;
    logic [7:0] w_byte_shift;
    logic       w_sync_match;
    logic       w_load;
    logic       w_last_byte;
    logic       w_abort;
    logic [1:0] w_abort_code;
    logic       w_handshake;

    assign w_sym        = zero_detect ^ one_detect;
    assign w_conflict   = zero_detect & one_detect;
    assign w_strobe     = zero_detect | one_detect;
    assign w_bit        = one_detect;
    assign w_sync_shift = {r_sync_sr[6:0], w_bit};
    assign w_byte_shift = {r_byte_sr[6:0], w_bit};
    assign w_handshake  = r_byte_valid && byte_ready;

    // A conflicting strobe pair still counts as activity on the line.
    pie_symbol_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_symbol_timer (
        .sclk_3mhz (sclk_3mhz),
        .reset     (reset),
        .i_clear   (w_strobe),
        .o_expired (w_expired)
    );

    always_ff @(posedge sclk_3mhz) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sync_match = 1'b0;
        w_load       = 1'b0;
        w_last_byte  = 1'b0;
        w_abort      = 1'b0;
        w_abort_code = ERR_NONE;
        case (r_state)
            HUNT: begin
                if (w_sym && (w_sync_shift == SYNC_WORD)) begin
                    w_sync_match = 1'b1;
                    w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // Conflict, overflow and timeout are mutually exclusive in
                // practice; the if-chain order fixes the priority anyway.
                if (w_conflict) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_CONFLICT;
                end else if (w_sym && (r_bit_cnt == 3'd7)) begin
                    if (r_byte_valid && !byte_ready) begin
                        w_abort      = 1'b1;
                        w_abort_code = ERR_OVERFLOW;
                    end else begin
                        w_load = 1'b1;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            w_last_byte  = 1'b1;
                            w_state_next = HUNT;
                        end
                    end
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_abort_code = ERR_TIMEOUT;
                end
                if (w_abort) begin
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge sclk_3mhz) begin
        if (reset) begin
            r_sync_sr     <= '0;
            r_byte_sr     <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_byte_data   <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_error_code  <= ERR_NONE;
        end else begin
            r_frame_done  <= w_last_byte;
            r_frame_error <= w_abort;

            // The sync register is left at zero whenever the FSM leaves HUNT,
            // so returning from PAYLOAD always starts a fresh hunt.
            if (r_state == HUNT) begin
                if (w_conflict || w_expired || w_sync_match) begin
                    r_sync_sr <= '0;
                end else if (w_sym) begin
                    r_sync_sr <= w_sync_shift;
                end
            end

            if (w_sync_match || w_abort) begin
                r_byte_sr <= '0;
                r_bit_cnt <= '0;
            end else if ((r_state == PAYLOAD) && w_sym) begin
                r_byte_sr <= w_byte_shift;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_sync_match) begin
                r_byte_cnt <= '0;
            end else if (w_load) begin
                r_byte_cnt <= r_byte_cnt + 4'd1;
            end

            // Loading bypasses byte_sr so byte_valid rises one cycle after
            // the 8th strobe; an overflow leaves the held byte untouched.
            if (w_load) begin
                r_byte_data  <= w_byte_shift;
                r_byte_valid <= 1'b1;
            end else if (w_handshake) begin
                r_byte_valid <= 1'b0;
            end

            if (w_sync_match) begin
                r_error_code <= ERR_NONE;
            end else if (w_abort) begin
                r_error_code <= w_abort_code;
            end
        end
    end

    assign byte_data    = r_byte_data;
    assign byte_valid   = r_byte_valid;
    assign frame_active = (r_state == PAYLOAD);
    assign frame_done   = r_frame_done;
    assign frame_error  = r_frame_error;
    assign error_code   = r_error_code;

endmodule
`default_nettype wire
